// File: rtl/key_cond_pkg.sv
// Shared constants, types and sizing helper for the key conditioner.
// KEY_COUNT_DEFAULT and DEBOUNCE_CYCLES_DEFAULT are the defaults the parameterised modules start from.
package key_cond_pkg;

  localparam int KEY_COUNT_DEFAULT       = 4;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;

  // The keys are active-low, so the accepted level is encoded the same way.
  typedef enum logic {
    KEY_DOWN = 1'b0,
    KEY_UP   = 1'b1
  } key_level_e;

  function automatic int cnt_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/key_conditioner4_if.sv
// Key bundle between the board keys and the consumer of the conditioned keys.
// The strobes are single-cycle and cannot be stalled: there is no valid/ready backpressure on this interface.
interface key_conditioner4_if import key_cond_pkg::*; #(
  parameter int KEY_COUNT = KEY_COUNT_DEFAULT
);
  logic [KEY_COUNT-1:0] key_raw;
  logic [KEY_COUNT-1:0] pressed;
  logic [KEY_COUNT-1:0] press_pulse;
  logic [KEY_COUNT-1:0] release_pulse;

  modport master (output key_raw, input pressed, press_pulse, release_pulse);
  modport slave  (input key_raw, output pressed, press_pulse, release_pulse);
endinterface

// File: rtl/key_debounce1.sv
// One key: two-flop synchronizer, stability counter, accepted level and edge strobes.
// The counter never wraps; a single agreeing sample restarts the count.
module key_debounce1 import key_cond_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clock,
  input  logic resetn,
  input  logic resetn_sync,
  input  logic key_raw,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             synced;
  key_level_e       stable;
  logic [CNT_W-1:0] cnt;

  // Synchronizer flops release on the raw reset so the key is already sampled
  // while the shared reset synchronizer is still holding the counter logic.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) sync_q <= 2'b11;
    else         sync_q <= {sync_q[0], key_raw};
  end

  assign synced = sync_q[1];

  always_ff @(posedge clock or negedge resetn_sync) begin
    if (!resetn_sync) begin
      stable        <= KEY_UP;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      if (synced == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable        <= key_level_e'(synced);
        cnt           <= '0;
        press_pulse   <= ~synced;
        release_pulse <= synced;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign pressed = (stable == KEY_DOWN);

endmodule

// File: rtl/key_conditioner4.sv
// Debounces KEY_COUNT active-low board keys into levels plus press/release strobes.
// Reset assertion is immediate; deassertion is synchronized once and shared by all keys.
module key_conditioner4 import key_cond_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int KEY_COUNT       = KEY_COUNT_DEFAULT
) (
  input logic              clock,
  input logic              resetn,
  key_conditioner4_if.slave kif
);

  logic [1:0]           rst_pipe;
  logic                 resetn_sync;
  logic [KEY_COUNT-1:0] pressed_w;
  logic [KEY_COUNT-1:0] press_w;
  logic [KEY_COUNT-1:0] release_w;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) rst_pipe <= 2'b00;
    else         rst_pipe <= {rst_pipe[0], 1'b1};
  end

  assign resetn_sync = rst_pipe[1];

  for (genvar i = 0; i < KEY_COUNT; i++) begin : g_key
    key_debounce1 #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
      .clock        (clock),
      .resetn       (resetn),
      .resetn_sync  (resetn_sync),
      .key_raw      (kif.key_raw[i]),
      .pressed      (pressed_w[i]),
      .press_pulse  (press_w[i]),
      .release_pulse(release_w[i])
    );
  end

  assign kif.pressed       = pressed_w;
  assign kif.press_pulse   = press_w;
  assign kif.release_pulse = release_w;

endmodule

// File: doc/key_conditioner4.md
KEY_CONDITIONER4 -- requirements
Module: key_conditioner4

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, SHALL set the stable-sample count needed to accept a key change (1 ms at 50 MHz); legal range ≥ 2.
REQ-002 Parameter KEY_COUNT, default 4, SHALL set the number of conditioned keys.
REQ-003 clock  input  1  single system clock; all state SHALL be clocked on its rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 key_raw  input  KEY_COUNT  raw board keys, asynchronous to clock, active-low (0 = pushed).
REQ-006 pressed  output  KEY_COUNT  debounced level, active-high (1 = pushed).
REQ-007 press_pulse  output  KEY_COUNT  one-cycle strobe on each accepted push.
REQ-008 release_pulse  output  KEY_COUNT  one-cycle strobe on each accepted release; this is the strobe that drives the shift register's clock-enable and function-capture point in place of raw KEY edges.

Function
REQ-009 Each key_raw bit SHALL pass through a two-flop synchronizer before any other logic.
REQ-010 Each key SHALL hold a registered stable state plus a counter of width clog2(DEBOUNCE_CYCLES).
REQ-011 Counter rule, per clock edge: synced == stable -> counter cleared to 0; synced != stable and counter < DEBOUNCE_CYCLES-1 -> counter increments by 1; synced != stable and counter == DEBOUNCE_CYCLES-1 -> stable takes synced and the counter clears.
REQ-012 A single sample with synced == stable during counting SHALL restart the count from 0 (glitch rejection); the counter SHALL never wrap.
REQ-013 Latency: a clean raw transition SHALL update pressed on the (2 + DEBOUNCE_CYCLES)-th rising edge after key_raw first settles at the new level.
REQ-014 press_pulse[i] SHALL be high for exactly the one cycle after the edge at which stable goes 1 -> 0; release_pulse[i] likewise for 0 -> 1. Both SHALL be registered and aligned with the pressed change.
REQ-015 press_pulse[i] and release_pulse[i] SHALL never be high in the same cycle; successive pulses on one key SHALL be at least DEBOUNCE_CYCLES cycles apart.
REQ-016 Keys SHALL be fully independent; simultaneous changes on several keys SHALL produce their pulses in the same cycle.
REQ-017 A key held indefinitely SHALL produce exactly one press_pulse and no repeats.

Reset
REQ-018 On resetn = 0, synchronizer flops and the stable state SHALL be set to 1 (released) and counters to 0. pressed, press_pulse and release_pulse SHALL read 0.
REQ-019 Deassertion of resetn SHALL be synchronized to clock using a two-flop reset synchronizer; assertion takes effect immediately.
REQ-020 A key held through reset release SHALL produce one press_pulse DEBOUNCE_CYCLES + 2 cycles after reset deasserts. No release_pulse SHALL be emitted spuriously.
REQ-021 Reset asserted mid-count SHALL discard the count; no pulse SHALL be emitted for the interrupted transition.

Structure
REQ-022 Package key_cond_pkg SHALL hold KEY_COUNT, the DEBOUNCE_CYCLES default, and the counter-width function.
REQ-023 Sub-module key_debounce1 (synchronizer, counter, stable state, pulse registers for one key) SHALL be instantiated KEY_COUNT times by generate.
REQ-024 The reset synchronizer SHALL live in key_conditioner4 and be shared by all instances.

Verification (DEBOUNCE_CYCLES = 4)
REQ-025 Reset test: resetn low, key_raw = 4'b0000 -> pressed = 0 and pulses = 0 during reset. After release: press_pulse = 4'b1111 for one cycle, 6 edges later.
REQ-026 Clean press key0: key_raw 1111 -> 1110 -> pressed[0] rises on edge 6 with press_pulse[0] for one cycle. Release -> release_pulse[0] for one cycle, 6 edges after release.
REQ-027 Glitch key1: low for 3 cycles, high 1, low again -> no pulse until 4 consecutive stable samples; exactly one press_pulse[1].
REQ-028 Bounce: key2 toggles every cycle for 20 cycles, then stays low -> exactly one press_pulse[2]; no release_pulse[2].
REQ-029 Simultaneous: key_raw 1111 -> 0101 in one cycle -> press_pulse = 4'b1010 in a single cycle.
REQ-030 Reset mid-count: key3 pressed, resetn pulsed low after 2 stable samples -> no pulse before reset. A fresh 6-edge latency measured from reset release -> single press_pulse[3].
